pc_gen_btb: RTL
===============

# pc_gen_btb

Parametrised program-counter generator for the yadan fetch stage, the successor to the fixed-width PC register. It holds the fetch PC and issues it to instruction fetch through a valid/ready handshake. Each cycle it selects the next PC from four sources in fixed priority: trap redirect, execute-stage branch redirect, a small direct-mapped branch target buffer (BTB) prediction, or sequential increment with wrap. It sits between the execute/CSR redirect logic and the instruction-fetch interface.

## Interface
- ADDR_W, 32, PC and target address width
- START_ADDR, 32'h0000_0000, reset vector and wrap destination
- END_ADDR, 32'h0000_3FFC, last sequential fetch address before wrap
- INST_BYTES, 4, sequential increment; only 4 is legal
- BTB_DEPTH, 4, BTB entry count; power of 2, 2..64

- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- trap_valid_i  in  1  trap/mret redirect request
- trap_addr_i  in  ADDR_W  trap target
- branch_flag_i  in  1  resolved taken branch/jump redirect
- branch_addr_i  in  ADDR_W  branch target
- branch_pc_i  in  ADDR_W  PC of the resolved branch; used for BTB update
- btb_flush_i  in  1  invalidate all BTB entries (fence.i)
- stall_i  in  1  fetch-stage stall from the hazard unit
- fetch_ready_i  in  1  fetch interface accepts the PC
- fetch_valid_o  out  1  fetch_pc_o is valid
- fetch_pc_o  out  ADDR_W  current fetch PC
- pred_taken_o  out  1  BTB hit for fetch_pc_o; combinational from fetch_pc_o and BTB state

## Operation
- Reset values:
  - fetch_pc_o = START_ADDR
  - internal valid_q = 0, so fetch_valid_o = 0
  - all BTB valid bits = 0, so pred_taken_o = 0
- valid_q sets to 1 on the first clock after rst deasserts. It stays 1 until the next reset.
- fetch_valid_o = valid_q & ~stall_i.
- A transfer ("fire") occurs when fetch_valid_o & fetch_ready_i.
- Redirect addresses (trap and branch) have bits [1:0] forced to 0 before they are used.
- Next-PC priority, evaluated every cycle:
  1. trap_valid_i: PC <= trap_addr_i. Applies regardless of stall or fire.
  2. branch_flag_i: PC <= branch_addr_i. Applies regardless of stall or fire.
  3. fire and BTB hit: PC <= BTB target.
  4. fire and no hit: if PC < END_ADDR, PC <= PC + INST_BYTES; otherwise PC <= START_ADDR.
  5. Otherwise PC holds.
- A redirect is never lost to a stall. It is applied on the same edge it is presented.
- BTB organisation:
  - Direct-mapped, with IDX_W = log2(BTB_DEPTH).
  - Index = PC[IDX_W+1:2].
  - Tag = PC[ADDR_W-1:IDX_W+2].
  - Entry contents: valid bit, tag, target[ADDR_W-1:2].
- Hit: entry[index(fetch_pc_o)].valid and the stored tag equals the tag of fetch_pc_o.
- BTB update: on branch_flag_i & ~trap_valid_i, write entry[index(branch_pc_i)] with valid = 1, tag(branch_pc_i), and branch_addr_i. Any existing entry at that index is overwritten.
- btb_flush_i clears all valid bits. If a flush and an update occur in the same cycle, the flush wins and no entry is written.
- Not-taken branches do not update the BTB. A stale entry is corrected only when it is overwritten or flushed.
- Arithmetic: the increment is ADDR_W-bit unsigned, and the END_ADDR comparison is unsigned.
- A BTB target is used even when it is greater than END_ADDR. The wrap check applies only to the sequential path.

## Timing
- Every redirect or advance takes effect on the next rising edge; fetch_pc_o is visible one cycle after the request.
- The first fetch_valid_o = 1 occurs in the second cycle after reset release (the cycle after valid_q sets).
- pred_taken_o has zero latency from fetch_pc_o. BTB writes become visible to lookups one cycle after the update edge. A same-cycle lookup at the index being written sees the old contents.
- The fetch PC and valid hold stable while fetch_valid_o & ~fetch_ready_i, unless a redirect arrives.
- Reset asserted mid-operation: all state returns to reset values asynchronously, with no dependency on the clock.

## Test plan
- Reset release, fetch_ready_i = 1, no redirects -> fetch_pc_o steps 0x0, 0x4, 0x8, ...; fetch_valid_o rises in the second cycle after release.
- fetch_pc_o = 0x3FFC fires -> next fetch_pc_o = 0x0000. stall_i = 1 for 3 cycles -> fetch_valid_o = 0 and the PC holds.
- stall_i = 1 together with branch_flag_i, branch_addr_i = 0x100 -> fetch_pc_o = 0x100 next cycle. trap_valid_i (0x80) and branch (0x100) in the same cycle -> 0x80.
- Branch at branch_pc_i = 0x20, target 0x200. A later sequential fetch of 0x20 -> pred_taken_o = 1 and the next fetch_pc_o = 0x200. Fetch of 0x1020 (same index, different tag) -> pred_taken_o = 0.
- btb_flush_i pulse, then a fetch of 0x20 -> pred_taken_o = 0 and next PC = 0x24. Flush and update in the same cycle -> no hit afterwards.
- rst asserted mid-stream at fetch_pc_o = 0x44 -> fetch_pc_o = 0x0, fetch_valid_o = 0, and the BTB is empty immediately, before the next edge.

Source files
------------

// File: rtl/pc_gen_btb_if.sv
// pc_gen_btb_if
// Bundles the redirect inputs and the fetch handshake of the PC generator.
//   master : PC generator side (drives fetch_valid_o, fetch_pc_o, pred_taken_o)
//   slave  : environment side (drives redirects, flush, stall, fetch_ready_i)
// Signals:
//   trap_valid_i/trap_addr_i                 trap or mret redirect
//   branch_flag_i/branch_addr_i/branch_pc_i  resolved taken branch and its PC
//   btb_flush_i                              invalidate the whole BTB
//   stall_i                                  fetch-stage stall
//   fetch_ready_i/fetch_valid_o/fetch_pc_o   fetch handshake
//   pred_taken_o                             BTB hit for fetch_pc_o
interface pc_gen_btb_if #(
  parameter int ADDR_W = 32
);
  logic              trap_valid_i;
  logic [ADDR_W-1:0] trap_addr_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_addr_i;
  logic [ADDR_W-1:0] branch_pc_i;
  logic              btb_flush_i;
  logic              stall_i;
  logic              fetch_ready_i;
  logic              fetch_valid_o;
  logic [ADDR_W-1:0] fetch_pc_o;
  logic              pred_taken_o;

  modport master (
    input  trap_valid_i, trap_addr_i, branch_flag_i, branch_addr_i, branch_pc_i,
    input  btb_flush_i, stall_i, fetch_ready_i,
    output fetch_valid_o, fetch_pc_o, pred_taken_o
  );

  modport slave (
    output trap_valid_i, trap_addr_i, branch_flag_i, branch_addr_i, branch_pc_i,
    output btb_flush_i, stall_i, fetch_ready_i,
    input  fetch_valid_o, fetch_pc_o, pred_taken_o
  );
endinterface

// File: rtl/pc_gen_btb.sv
// pc_gen_btb
// Fetch program-counter generator with a direct-mapped branch target buffer.
// Next PC priority: trap redirect, branch redirect, BTB prediction on a
// transfer, sequential increment (wrapping from END_ADDR to START_ADDR).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pc_gen_btb_if.master (redirects, flush, stall, fetch handshake)
module pc_gen_btb #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 32'h0000_3FFC,
  parameter int                INST_BYTES = 4,
  parameter int                BTB_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_gen_btb_if.master  bus
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int TGT_W = ADDR_W - 2;

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              valid_reg;

  logic [BTB_DEPTH-1:0] btb_valid_reg;
  logic [TAG_W-1:0]     btb_tag_reg [BTB_DEPTH];
  logic [TGT_W-1:0]     btb_tgt_reg [BTB_DEPTH];

  logic              fetch_valid;
  logic              fire;
  logic              hit;
  logic [IDX_W-1:0]  fetch_idx;
  logic [TAG_W-1:0]  fetch_tag;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              btb_write;
  logic [ADDR_W-1:0] trap_tgt;
  logic [ADDR_W-1:0] branch_tgt;

  // Low address bits are dropped on redirects and ignored on the branch PC.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.trap_addr_i[1:0], bus.branch_addr_i[1:0],
                             bus.branch_pc_i[1:0]};

  assign trap_tgt   = {bus.trap_addr_i[ADDR_W-1:2], 2'b00};
  assign branch_tgt = {bus.branch_addr_i[ADDR_W-1:2], 2'b00};

  assign fetch_valid = valid_reg & ~bus.stall_i;
  assign fire        = fetch_valid & bus.fetch_ready_i;

  // Lookup is purely combinational on the current PC, so a write on this
  // edge is only seen from the following cycle.
  assign fetch_idx = pc_reg[IDX_W+1:2];
  assign fetch_tag = pc_reg[ADDR_W-1:IDX_W+2];
  assign hit       = btb_valid_reg[fetch_idx] && (btb_tag_reg[fetch_idx] == fetch_tag);

  assign upd_idx   = bus.branch_pc_i[IDX_W+1:2];
  assign upd_tag   = bus.branch_pc_i[ADDR_W-1:IDX_W+2];
  // A trap squashes the branch, and a flush overrides any write.
  assign btb_write = bus.branch_flag_i & ~bus.trap_valid_i & ~bus.btb_flush_i;

  always_comb begin
    pc_next = pc_reg;
    if (bus.trap_valid_i) begin
      pc_next = trap_tgt;
    end else if (bus.branch_flag_i) begin
      pc_next = branch_tgt;
    end else if (fire) begin
      if (hit) begin
        // Predicted targets bypass the wrap check.
        pc_next = {btb_tgt_reg[fetch_idx], 2'b00};
      end else if (pc_reg < END_ADDR) begin
        pc_next = pc_reg + ADDR_W'(INST_BYTES);
      end else begin
        pc_next = START_ADDR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= START_ADDR;
      valid_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      valid_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BTB_DEPTH; gi++) begin : g_btb
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          btb_valid_reg[gi] <= 1'b0;
        end else if (bus.btb_flush_i) begin
          btb_valid_reg[gi] <= 1'b0;
        end else if (btb_write && (upd_idx == IDX_W'(gi))) begin
          btb_valid_reg[gi] <= 1'b1;
        end
      end

      // Tag and target need no reset: they are qualified by the valid bit.
      always_ff @(posedge clk) begin
        if (btb_write && (upd_idx == IDX_W'(gi))) begin
          btb_tag_reg[gi] <= upd_tag;
          btb_tgt_reg[gi] <= branch_tgt[ADDR_W-1:2];
        end
      end
    end
  endgenerate

  assign bus.fetch_valid_o = fetch_valid;
  assign bus.fetch_pc_o    = pc_reg;
  assign bus.pred_taken_o  = hit;
endmodule
